// File: rtl/pll_seq_pkg.sv
// Shared types and helpers for the PLL reset sequencer.
//   state_t   : sequencer state encoding (3-bit binary)
//   RETRY_W   : width of the retry counter
//   cnt_width : width of the shared phase counter for a given set of phase lengths
package pll_seq_pkg;

    localparam int unsigned RETRY_W = 4;

    typedef enum logic [2:0] {
        S_PLL_RST   = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_RUN       = 3'd3,
        S_FAIL      = 3'd4
    } state_t;

    // Counter must hold the largest phase length minus one, plus a spare bit.
    function automatic int unsigned cnt_width(input int unsigned a,
                                              input int unsigned b,
                                              input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/pll_reset_sequencer_if.sv
// PLL-side and system-side signals of the reset sequencer.
//   master : sequencer view (samples lock/soft request, drives resets and status)
//   slave  : environment view (PLL + system controller)
interface pll_reset_sequencer_if;
    import pll_seq_pkg::*;

    logic               pll_locked;
    logic               soft_reset_req;
    logic               pll_rst;
    logic               sys_reset_n;
    logic               ready;
    logic               fail;
    logic               lock_lost;
    logic [RETRY_W-1:0] retry_count;

    modport master (
        input  pll_locked, soft_reset_req,
        output pll_rst, sys_reset_n, ready, fail, lock_lost, retry_count
    );

    modport slave (
        output pll_locked, soft_reset_req,
        input  pll_rst, sys_reset_n, ready, fail, lock_lost, retry_count
    );

endinterface

// File: rtl/bit_synchronizer.sv
// Multi-flop synchronizer for a single asynchronous bit.
//   clk, rst_n : destination clock, async active-low reset (chain clears to 0)
//   d          : asynchronous input
//   q          : synchronized output (last flop of the chain)
module bit_synchronizer #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    // Shift d in at bit 0; the oldest sample leaves at the top.
    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= '0;
        else        sync_q <= sync_d;
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer: pulses the PLL reset, waits for lock with timeout and
// bounded retries, and releases the system reset after lock has been stable.
//   clk, reset_n : reference clock, async active-low reset
//   bus (master) : pll_locked, soft_reset_req in;
//                  pll_rst, sys_reset_n, ready, fail, lock_lost, retry_count out
module pll_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter int unsigned PLL_RST_CYCLES      = 16,
    parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 50000,
    parameter int unsigned MAX_RETRIES         = 3,
    parameter int unsigned SYNC_STAGES         = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    pll_reset_sequencer_if.master bus
);

    localparam int unsigned CNT_W =
        cnt_width(PLL_RST_CYCLES, LOCK_STABLE_CYCLES, LOCK_TIMEOUT_CYCLES);

    localparam logic [CNT_W-1:0]   RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX    = RETRY_W'(MAX_RETRIES);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic               pll_rst_q, pll_rst_d;
    logic               sys_reset_n_q, sys_reset_n_d;
    logic               ready_q, ready_d;
    logic               fail_q, fail_d;
    logic               lock_lost_q, lock_lost_d;
    logic               lock_s;

    // Lock is asynchronous to clk; every decision uses the synchronized copy.
    bit_synchronizer #(
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk   (clk),
        .rst_n (reset_n),
        .d     (bus.pll_locked),
        .q     (lock_s)
    );

    // Next state, counter, retry count and registered output decode.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        retry_d     = retry_q;
        lock_lost_d = 1'b0;

        case (state_q)
            S_PLL_RST: begin
                if (cnt_q == RST_LAST) state_d = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
                if (lock_s) begin
                    state_d = S_STABLE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    if (retry_q == RETRY_MAX) begin
                        state_d = S_FAIL;
                    end else begin
                        retry_d = retry_q + RETRY_W'(1);
                        state_d = S_PLL_RST;
                    end
                end
            end
            S_STABLE: begin
                // A lock glitch restarts the wait without consuming a retry.
                if (!lock_s)                    state_d = S_WAIT_LOCK;
                else if (cnt_q == STABLE_LAST)  state_d = S_RUN;
            end
            S_RUN: begin
                if (!lock_s) begin
                    lock_lost_d = 1'b1;
                    state_d     = S_PLL_RST;
                end
            end
            S_FAIL: begin
                retry_d = RETRY_MAX;
            end
            default: begin
                state_d = S_PLL_RST;
            end
        endcase

        if (state_d == S_RUN) retry_d = '0;

        // Soft reset overrides everything except the lock_lost report.
        if (bus.soft_reset_req) begin
            state_d = S_PLL_RST;
            retry_d = '0;
        end

        // Counter restarts on any state change or soft reset; it only runs
        // in the timed states so it never wraps.
        if (state_d != state_q || bus.soft_reset_req) begin
            cnt_d = '0;
        end else if (state_q == S_PLL_RST || state_q == S_WAIT_LOCK ||
                     state_q == S_STABLE) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        pll_rst_d     = (state_d == S_PLL_RST) || (state_d == S_FAIL);
        sys_reset_n_d = (state_d == S_RUN);
        ready_d       = (state_d == S_RUN);
        fail_d        = (state_d == S_FAIL);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_PLL_RST;
            cnt_q         <= '0;
            retry_q       <= '0;
            pll_rst_q     <= 1'b1;
            sys_reset_n_q <= 1'b0;
            ready_q       <= 1'b0;
            fail_q        <= 1'b0;
            lock_lost_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            retry_q       <= retry_d;
            pll_rst_q     <= pll_rst_d;
            sys_reset_n_q <= sys_reset_n_d;
            ready_q       <= ready_d;
            fail_q        <= fail_d;
            lock_lost_q   <= lock_lost_d;
        end
    end

    assign bus.pll_rst     = pll_rst_q;
    assign bus.sys_reset_n = sys_reset_n_q;
    assign bus.ready       = ready_q;
    assign bus.fail        = fail_q;
    assign bus.lock_lost   = lock_lost_q;
    assign bus.retry_count = retry_q;

endmodule
